azadi_pinmux_ctrl: RTL and testbench

Wishbone-configurable pad-ownership controller for the user-project IO pads. Each pad is owned by one of NUM_FUNC peripheral functions (0 = GPIO, 1..3 = alternates such as JTAG/PWM/SPI/UART); the block muxes the owner's out/oe onto the pad. Ownership changes are sequenced one pad at a time through a guard (isolation) window, so a pad is never driven by two owners or glitched. It sits between azadi_soc_top peripheral outputs and the caravel io_out/io_oeb pins.

---
 rtl/azadi_pinmux_pkg.sv | 34 +++
 rtl/azadi_pinmux_ctrl_if.sv | 14 +
 rtl/azadi_pinmux_regs.sv | 81 ++++++++
 rtl/azadi_pinmux_ctrl.sv | 116 +++++++++++
 tb/tb_azadi_pinmux_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/azadi_pinmux_pkg.sv
// Shared types and register map for the pad-ownership controller.
package azadi_pinmux_pkg;

  typedef enum logic [1:0] {
    FUNC_GPIO = 2'd0,
    FUNC_ALT1 = 2'd1,
    FUNC_ALT2 = 2'd2,
    FUNC_ALT3 = 2'd3
  } func_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISOLATE = 2'd1,
    COMMIT  = 2'd2
  } state_e;

  // Word offsets, i.e. wbs_adr_i[7:2]
  localparam logic [5:0] ADR_CTRL   = 6'h00;
  localparam logic [5:0] ADR_STATUS = 6'h01;
  localparam logic [5:0] ADR_TGT0   = 6'h04;
  localparam logic [5:0] ADR_TGT1   = 6'h05;
  localparam logic [5:0] ADR_TGT2   = 6'h06;

  localparam int CTRL_LOCK   = 31;
  localparam int STATUS_BUSY = 0;
  localparam int STATUS_ERR  = 1;
  localparam int GUARD_RST   = 2;
  localparam int TGT_BITS    = 96;

  function automatic logic is_tgt(input logic [5:0] w);
    return (w == ADR_TGT0) || (w == ADR_TGT1) || (w == ADR_TGT2);
  endfunction

endpackage

// File: rtl/azadi_pinmux_ctrl_if.sv
// Wishbone slave bus bundle for the pinmux register block.
interface azadi_pinmux_ctrl_if;
  logic        stb;
  logic        cyc;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output stb, cyc, we, sel, adr, wdata, input ack, rdata);
  modport slave  (input stb, cyc, we, sel, adr, wdata, output ack, rdata);
endinterface

// File: rtl/azadi_pinmux_regs.sv
// Wishbone register file: guard/lock control, sticky error, per-pad target owners.
module azadi_pinmux_regs
  import azadi_pinmux_pkg::*;
#(
  parameter int NUM_PADS = 38,
  parameter int GUARD_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  azadi_pinmux_ctrl_if.slave    bus,
  input  logic                  busy,
  output logic [GUARD_W-1:0]    guard,
  output logic [2*NUM_PADS-1:0] tgt
);

  logic [5:0]          word;
  logic [1:0]          tword;
  logic                req, wr, rd;
  logic                ack_q, lock_q, err_q;
  logic [31:0]         rdata_q, rd_mux;
  logic [TGT_BITS-1:0] tgt_ext;
  logic                unused_adr;

  assign word       = bus.adr[7:2];
  assign tword      = 2'(word - ADR_TGT0);
  assign req        = bus.stb & bus.cyc & ~ack_q;
  assign wr         = req & bus.we;
  assign rd         = req & ~bus.we;
  assign tgt_ext    = TGT_BITS'(tgt);
  assign unused_adr = ^{bus.adr[31:8], bus.adr[1:0]};

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;

  always_comb begin
    rd_mux = '0;
    if (word == ADR_CTRL) begin
      rd_mux[GUARD_W-1:0] = guard;
      rd_mux[CTRL_LOCK]   = lock_q;
    end else if (word == ADR_STATUS) begin
      rd_mux[STATUS_BUSY] = busy;
      rd_mux[STATUS_ERR]  = err_q;
    end else if (is_tgt(word)) begin
      rd_mux = tgt_ext[{tword, 5'b0} +: 32];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      guard   <= GUARD_W'(GUARD_RST);
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
      tgt     <= '0;
    end else begin
      ack_q   <= req;
      rdata_q <= rd ? rd_mux : '0;
      if (wr) begin
        if (word == ADR_CTRL) begin
          // Once locked only a reset reopens the guard and target fields.
          if (lock_q) err_q <= 1'b1;
          else begin
            if (bus.sel[0]) guard <= bus.wdata[GUARD_W-1:0];
            if (bus.sel[3] && bus.wdata[CTRL_LOCK]) lock_q <= 1'b1;
          end
        end else if (word == ADR_STATUS) begin
          if (bus.sel[0] && bus.wdata[STATUS_ERR]) err_q <= 1'b0;
        end else if (is_tgt(word)) begin
          if (lock_q) err_q <= 1'b1;
          else begin
            for (int b = 0; b < 2*NUM_PADS; b++)
              if ((b / 32) == int'(tword) && bus.sel[(b % 32) / 8])
                tgt[b] <= bus.wdata[b % 32];
          end
        end
      end
    end
  end

endmodule

// File: rtl/azadi_pinmux_ctrl.sv
// Pad-ownership controller: hands pads to new owners one at a time through an
// isolation window, then muxes the committed owner's out/oe onto the pad.
module azadi_pinmux_ctrl
  import azadi_pinmux_pkg::*;
#(
  parameter int NUM_PADS = 38,
  parameter int NUM_FUNC = 4,
  parameter int GUARD_W  = 4
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  azadi_pinmux_ctrl_if.slave           wbs,
  input  logic [NUM_FUNC*NUM_PADS-1:0] fn_out_i,
  input  logic [NUM_FUNC*NUM_PADS-1:0] fn_oe_i,
  output logic [NUM_PADS-1:0]          io_out_o,
  output logic [NUM_PADS-1:0]          io_oeb_o,
  output logic [2*NUM_PADS-1:0]        sel_o,
  output logic                         busy_o
);

  localparam int IDX_W = $clog2(NUM_PADS);

  logic [GUARD_W-1:0]       guard;
  logic [NUM_PADS-1:0][1:0] tgt, cur;
  logic [NUM_PADS-1:0]      pending;
  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         pad_q, pad_d, first_idx;
  logic [GUARD_W-1:0]       cnt_q, cnt_d;

  azadi_pinmux_regs #(.NUM_PADS(NUM_PADS), .GUARD_W(GUARD_W)) u_regs (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .bus   (wbs),
    .busy  (busy_o),
    .guard (guard),
    .tgt   (tgt)
  );

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pend
    assign pending[p] = (tgt[p] != cur[p]);
  end

  always_comb begin
    first_idx = '0;
    for (int p = NUM_PADS-1; p >= 0; p--)
      if (pending[p]) first_idx = IDX_W'(p);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      pad_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pad_q   <= pad_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pad_d   = pad_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (|pending) begin
        pad_d   = first_idx;
        cnt_d   = (guard == '0) ? GUARD_W'(1) : guard;
        state_d = ISOLATE;
      end
      ISOLATE: if (cnt_q <= GUARD_W'(1)) state_d = COMMIT;
               else cnt_d = cnt_q - GUARD_W'(1);
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Commit takes the target as it stands now, so a retarget during isolation
  // lands without a second handover.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) cur <= '0;
    else if (state_q == COMMIT) cur[pad_q] <= tgt[pad_q];
  end

  assign sel_o  = cur;
  assign busy_o = (state_q != IDLE) | (|pending);

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    logic [NUM_FUNC-1:0] outs, oes;
    logic                iso, out_q, oeb_q;

    for (genvar f = 0; f < NUM_FUNC; f++) begin : g_fn
      assign outs[f] = fn_out_i[f*NUM_PADS+p];
      assign oes[f]  = fn_oe_i[f*NUM_PADS+p];
    end

    assign iso = (state_q != IDLE) && (pad_q == IDX_W'(p));

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
        out_q <= 1'b0;
        oeb_q <= 1'b1;
      end else if (iso) begin
        out_q <= 1'b0;
        oeb_q <= 1'b1;
      end else begin
        out_q <= outs[cur[p]];
        oeb_q <= ~oes[cur[p]];
      end
    end

    assign io_out_o[p] = out_q;
    assign io_oeb_o[p] = oeb_q;
  end

endmodule

// File: tb/tb_azadi_pinmux_ctrl.sv
// Directed + randomized bench for azadi_pinmux_ctrl with a register/ownership model.
module tb_azadi_pinmux_ctrl;

  localparam int NP = 38;
  localparam int NF = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  azadi_pinmux_ctrl_if bus();
  logic [NF*NP-1:0] fn_out, fn_oe;
  logic [NP-1:0]    io_out, io_oeb;
  logic [2*NP-1:0]  sel;
  logic             busy;

  azadi_pinmux_ctrl #(.NUM_PADS(NP), .NUM_FUNC(NF), .GUARD_W(4)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs      (bus),
    .fn_out_i (fn_out),
    .fn_oe_i  (fn_oe),
    .io_out_o (io_out),
    .io_oeb_o (io_oeb),
    .sel_o    (sel),
    .busy_o   (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: SW-visible registers plus the owner each pad has settled on.
  int m_tgt[NP];
  int m_cur[NP];
  int m_guard;
  bit m_lock, m_err;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int p = 0; p < NP; p++) begin m_tgt[p] = 0; m_cur[p] = 0; end
    m_guard = 2; m_lock = 0; m_err = 0;
  endfunction

  function automatic void m_write(input logic [31:0] adr, input logic [31:0] d, input logic [3:0] be);
    int w;
    w = int'(adr[7:2]);
    if (w == 0) begin
      if (m_lock) m_err = 1;
      else begin
        if (be[0]) m_guard = int'(d[3:0]);
        if (be[3] && d[31]) m_lock = 1;
      end
    end else if (w == 1) begin
      if (be[0] && d[1]) m_err = 0;
    end else if (w >= 4 && w <= 6) begin
      if (m_lock) m_err = 1;
      else for (int k = 0; k < 16; k++) begin
        int p;
        p = (w - 4) * 16 + k;
        if (p < NP && be[k/4]) m_tgt[p] = int'(d[2*k +: 2]);
      end
    end
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] adr);
    logic [31:0] r;
    int w;
    r = '0;
    w = int'(adr[7:2]);
    if (w == 0) begin r[3:0] = 4'(m_guard); r[31] = m_lock; end
    else if (w == 1) r[1] = m_err;
    else if (w >= 4 && w <= 6)
      for (int k = 0; k < 16; k++) begin
        int p;
        p = (w - 4) * 16 + k;
        if (p < NP) r[2*k +: 2] = 2'(m_tgt[p]);
      end
    return r;
  endfunction

  function automatic logic [2*NP-1:0] m_sel();
    logic [2*NP-1:0] r;
    for (int p = 0; p < NP; p++) r[2*p +: 2] = 2'(m_cur[p]);
    return r;
  endfunction

  function automatic logic [NP-1:0] m_out();
    logic [NP-1:0] r;
    for (int p = 0; p < NP; p++) r[p] = fn_out[m_cur[p]*NP + p];
    return r;
  endfunction

  function automatic logic [NP-1:0] m_oeb();
    logic [NP-1:0] r;
    for (int p = 0; p < NP; p++) r[p] = ~fn_oe[m_cur[p]*NP + p];
    return r;
  endfunction

  function automatic logic [NP-1:0] m_pend();
    logic [NP-1:0] r;
    for (int p = 0; p < NP; p++) r[p] = (m_tgt[p] != m_cur[p]);
    return r;
  endfunction

  function automatic void m_settle();
    for (int p = 0; p < NP; p++) m_cur[p] = m_tgt[p];
  endfunction

  task automatic rand_fn(input bit oe_all);
    for (int i = 0; i < NF*NP; i++) begin
      fn_out[i] = 1'($urandom);
      fn_oe[i]  = oe_all ? 1'b1 : 1'($urandom);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] d,
                         input logic [3:0] be, output logic [31:0] rd);
    int t;
    @(negedge clk);
    bus.stb = 1'b1; bus.cyc = 1'b1; bus.we = we;
    bus.adr = adr; bus.wdata = d; bus.sel = be;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.ack && t < 10);
    rd = bus.rdata;
    check("wb_ack", 128'(bus.ack), 128'(1));
    bus.stb = 1'b0; bus.cyc = 1'b0; bus.we = 1'b0;
    if (we) m_write(adr, d, be);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] rd;
    wb_xfer(1'b1, adr, d, be, rd);
  endtask

  task automatic wb_read_check(input string tag, input logic [31:0] adr);
    logic [31:0] rd;
    wb_xfer(1'b0, adr, 32'h0, 4'hf, rd);
    check(tag, 128'(rd), 128'(m_read(adr)));
  endtask

  task automatic check_pads(input string tag);
    check({tag, "_out"}, 128'(io_out), 128'(m_out()));
    check({tag, "_oeb"}, 128'(io_oeb), 128'(m_oeb()));
  endtask

  // Observes a handover sequence starting on the write's ack sample. Requires
  // every owner's oe high so any oeb=1 means the pad is being isolated.
  task automatic watch(input string tag, input logic [NP-1:0] pads);
    int bc, tail, ov, g, c, k, bad, j;
    int fc[NP];
    int order[$];
    logic [NP-1:0] prev;
    bc = 0; tail = 0; ov = 0; c = 0; bad = 0; j = 0;
    prev = '0;
    for (int p = 0; p < NP; p++) fc[p] = 0;
    g = (m_guard == 0) ? 1 : m_guard;
    while (tail < 3 && c < 800) begin
      if (busy) bc++; else tail++;
      if ($countones(io_oeb) > 1) ov++;
      for (int p = 0; p < NP; p++)
        if (io_oeb[p]) begin
          fc[p]++;
          if (!prev[p]) order.push_back(p);
        end
      prev = io_oeb;
      c++;
      @(negedge clk);
    end
    k = $countones(pads);
    check({tag, "_busy_cycles"}, 128'(bc), 128'(k * (g + 2)));
    check({tag, "_overlap"}, 128'(ov), 128'(0));
    for (int p = 0; p < NP; p++) begin
      if (fc[p] != (pads[p] ? g + 1 : 0)) bad++;
      if (pads[p]) begin
        if (j >= order.size() || order[j] != p) bad++;
        j++;
      end
    end
    if (order.size() != k) bad++;
    check({tag, "_isolation"}, 128'(bad), 128'(0));
    m_settle();
    check({tag, "_sel"}, 128'(sel), 128'(m_sel()));
  endtask

  initial begin
    logic [31:0] d, a;
    logic [3:0]  be;
    int bc, fc5;

    bus.stb = 1'b0; bus.cyc = 1'b0; bus.we = 1'b0;
    bus.sel = 4'h0; bus.adr = '0; bus.wdata = '0;
    rand_fn(1'b0);
    m_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_oeb", 128'(io_oeb), 128'({NP{1'b1}}));
    check("rst_out", 128'(io_out), 128'(0));
    check("rst_sel", 128'(sel), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_ack", 128'(bus.ack), 128'(0));
    check("rst_rdata", 128'(bus.rdata), 128'(0));
    rst = 1'b0;
    wb_read_check("rst_ctrl", 32'h00);
    wb_read_check("rst_status", 32'h04);
    wb_read_check("rst_tgt0", 32'h10);
    @(negedge clk);
    check("ack_one_cycle", 128'(bus.ack), 128'(0));

    // GPIO datapath under random function values
    for (int i = 0; i < 3; i++) begin
      rand_fn(1'b0);
      repeat (2) @(negedge clk);
      check_pads("dp_gpio");
    end

    // Pad1 -> func2
    rand_fn(1'b1);
    wb_write(32'h10, 32'h0000_0008, 4'hf);
    watch("h_pad1", m_pend());
    rand_fn(1'b0);
    repeat (2) @(negedge clk);
    check_pads("dp_pad1");

    // Pads 0,2 -> func1 (pad1 back to GPIO): strictly sequential
    rand_fn(1'b1);
    wb_write(32'h10, 32'h0000_0011, 4'hf);
    watch("h_pad012", m_pend());
    rand_fn(1'b0);
    repeat (2) @(negedge clk);
    check_pads("dp_pad012");

    // Random guard, word, data and byte selects
    for (int i = 0; i < 4; i++) begin
      wb_write(32'h00, 32'($urandom_range(0, 5)), 4'h1);
      rand_fn(1'b1);
      a  = 32'h10 + 32'(4 * $urandom_range(0, 2));
      d  = $urandom;
      be = 4'($urandom_range(1, 15));
      wb_write(a, d, be);
      watch("h_rand", m_pend());
      wb_read_check("rand_tgt_rb", a);
      rand_fn(1'b0);
      repeat (2) @(negedge clk);
      check_pads("dp_rand");
    end
    wb_read_check("tgt2_rb", 32'h18);

    // Unmapped space
    wb_read_check("unmap_08", 32'h08);
    wb_read_check("unmap_1c", 32'h1C);
    wb_write(32'h0C, 32'hffff_ffff, 4'hf);
    wb_read_check("unmap_wr_ctrl", 32'h00);

    // Retarget pad5 during its one-cycle isolation (G=0)
    wb_write(32'h00, 32'h0, 4'h1);
    rand_fn(1'b1);
    d = m_read(32'h10);
    d[11:10] = 2'd0;
    wb_write(32'h10, d, 4'hf);
    watch("h_pad5_clear", m_pend());
    d[11:10] = 2'd1;
    wb_write(32'h10, d, 4'hf);
    d[11:10] = 2'd3;
    wb_write(32'h10, d, 4'hf);
    bc = 0; fc5 = 0;
    for (int c = 0; c < 10; c++) begin
      if (busy) bc++;
      if (io_oeb[5]) fc5++;
      @(negedge clk);
    end
    check("retgt_busy", 128'(bc), 128'(1));
    check("retgt_iso", 128'(fc5), 128'(2));
    m_settle();
    check("retgt_sel", 128'(sel), 128'(m_sel()));

    // Lock
    wb_write(32'h00, 32'h8000_0000, 4'hf);
    wb_read_check("lock_ctrl", 32'h00);
    wb_write(32'h10, 32'h0000_0003, 4'hf);
    repeat (5) @(negedge clk);
    check("lock_sel", 128'(sel), 128'(m_sel()));
    check("lock_busy", 128'(busy), 128'(0));
    wb_read_check("lock_status_err", 32'h04);
    wb_write(32'h00, 32'h0000_0005, 4'h1);
    wb_read_check("lock_ctrl_kept", 32'h00);
    wb_write(32'h04, 32'h0000_0002, 4'h1);
    wb_read_check("err_cleared", 32'h04);

    // Reset in the middle of pad1's isolation
    rst = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wb_read_check("rst2_ctrl", 32'h00);
    rand_fn(1'b1);
    wb_write(32'h10, 32'h0000_0008, 4'hf);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_oeb", 128'(io_oeb), 128'({NP{1'b1}}));
    check("midrst_out", 128'(io_out), 128'(0));
    check("midrst_sel", 128'(sel), 128'(0));
    check("midrst_busy", 128'(busy), 128'(0));
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    wb_read_check("midrst_tgt0", 32'h10);
    wb_read_check("midrst_ctrl", 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
